// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath: operand width,
// decoder FSM encoding and window-length helper.
package sc_pkg;

    localparam int SC_DATA_W = 8;

    // Fixed encodings so external tooling can decode the state field directly
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM,
        HOLD  = ST_HOLD
    } dec_state_t;

    function automatic int sc_window_len(input int len_log2);
        return 1 << len_log2;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Counts accepted stream samples and the ones among them over one window;
// flags the sample that completes the window.
module sc_ones_counter #(
    parameter int LEN_LOG2 = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                enable,
    input  logic                bit_in,
    output logic [LEN_LOG2:0]   ones_next,
    output logic                last_sample
);

    logic [LEN_LOG2-1:0] sample_cnt;
    logic [LEN_LOG2:0]   ones_cnt;

    // ones_next includes the sample being accepted this cycle, so the
    // final count is available on the same edge that closes the window
    assign ones_next   = ones_cnt + (LEN_LOG2+1)'(bit_in);
    assign last_sample = enable && (sample_cnt == {LEN_LOG2{1'b1}});

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (enable) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones_cnt   <= ones_next;
        end
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^LEN_LOG2 valid samples and
// presents the scaled count on a valid/ready handshake.
import sc_pkg::*;

module sc_stream_decoder #(
    parameter int DATA_W   = SC_DATA_W,
    parameter int LEN_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              bit_valid_i,
    input  logic              bit_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] result_o,
    output logic              sat_o,
    output logic              result_valid_o,
    input  logic              result_ready_i
);

    localparam int WIN_LEN = sc_window_len(LEN_LOG2);

    generate
        if (LEN_LOG2 < DATA_W) begin : g_bad_len
            $error("sc_stream_decoder: LEN_LOG2 must be >= DATA_W");
        end
    endgenerate

    dec_state_t          state;
    logic                cnt_clear;
    logic                cnt_enable;
    logic                last_sample;
    logic                handshake;
    logic [LEN_LOG2:0]   ones_next;
    logic                full_ones;

    assign handshake  = (state == HOLD) && result_ready_i;
    assign cnt_clear  = ((state == IDLE) && start_i) || (handshake && start_i);
    assign cnt_enable = (state == ACCUM) && bit_valid_i;
    assign full_ones  = (ones_next == (LEN_LOG2+1)'(WIN_LEN));

    sc_ones_counter #(
        .LEN_LOG2 (LEN_LOG2)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (cnt_clear),
        .enable      (cnt_enable),
        .bit_in      (bit_i),
        .ones_next   (ones_next),
        .last_sample (last_sample)
    );

    // start together with the handshake re-enters ACCUM without an IDLE bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start_i)     state <= ACCUM;
                ACCUM:   if (last_sample) state <= HOLD;
                HOLD:    if (handshake)   state <= start_i ? ACCUM : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A full window cannot be represented in DATA_W bits, so it clamps
    always_ff @(posedge clk) begin
        if (rst) begin
            result_o <= '0;
            sat_o    <= 1'b0;
        end else if (last_sample) begin
            if (full_ones) begin
                result_o <= '1;
                sat_o    <= 1'b1;
            end else begin
                result_o <= ones_next[LEN_LOG2-1 -: DATA_W];
                sat_o    <= 1'b0;
            end
        end
    end

    assign busy_o         = (state == ACCUM);
    assign result_valid_o = (state == HOLD);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed self-checking bench for sc_stream_decoder (8-bit/256-sample and
// 8-bit/1024-sample instances).
module tb_sc_stream_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, bit_valid, bit_in, ready;
    logic       busy, sat, rvalid;
    logic [7:0] result;

    logic       start10, bit_valid10, bit_in10, ready10;
    logic       busy10, sat10, rvalid10;
    logic [7:0] result10;

    int tests = 0;
    int fails = 0;

    sc_stream_decoder #(.DATA_W(8), .LEN_LOG2(8)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .bit_valid_i    (bit_valid),
        .bit_i          (bit_in),
        .busy_o         (busy),
        .result_o       (result),
        .sat_o          (sat),
        .result_valid_o (rvalid),
        .result_ready_i (ready)
    );

    sc_stream_decoder #(.DATA_W(8), .LEN_LOG2(10)) u_dut10 (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start10),
        .bit_valid_i    (bit_valid10),
        .bit_i          (bit_in10),
        .busy_o         (busy10),
        .result_o       (result10),
        .sat_o          (sat10),
        .result_valid_o (rvalid10),
        .result_ready_i (ready10)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: all ones, 1: 1,0 alternating, 2: all zeros, 3: repeating 1,1,1,0
    function automatic logic pat_bit(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 2) == 0;
            2:       return 1'b0;
            default: return (k % 4) != 3;
        endcase
    endfunction

    task automatic applyStimulus(input int mode, input bit gaps,
                                 output bit busy_ok, output bit early_valid);
        busy_ok     = 1'b1;
        early_valid = 1'b0;
        for (int k = 0; k < 256; k++) begin
            bit_valid = 1'b1;
            bit_in    = pat_bit(mode, k);
            tick();
            if (k < 255) begin
                if (busy !== 1'b1)  busy_ok     = 1'b0;
                if (rvalid !== 1'b0) early_valid = 1'b1;
                if (gaps) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'b1;
                    tick();
                    if (busy !== 1'b1)  busy_ok     = 1'b0;
                    if (rvalid !== 1'b0) early_valid = 1'b1;
                end
            end
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_handshake;
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++; if (busy !== 1'b0)   begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        tests++; if (rvalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b want 0", rvalid); end
        tests++; if (result !== 8'h00) begin fails++; $display("[TB] FAIL reset_result got %h want 00", result); end
        tests++; if (sat !== 1'b0)    begin fails++; $display("[TB] FAIL reset_sat got %b want 0", sat); end
        // stream samples in IDLE must not start anything
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        repeat (3) tick();
        bit_valid = 1'b0;
        tests++; if (busy !== 1'b0 || rvalid !== 1'b0) begin
            fails++; $display("[TB] FAIL idle_ignore got busy=%b valid=%b want 0/0", busy, rvalid);
        end
    endtask

    task automatic test_window(input string name, input int mode, input bit gaps,
                               input logic [7:0] exp_res, input logic exp_sat);
        bit busy_ok, early_valid;
        do_start();
        tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL %s_busy_start got %b want 1", name, busy); end
        applyStimulus(mode, gaps, busy_ok, early_valid);
        tests++; if (!busy_ok)    begin fails++; $display("[TB] FAIL %s_busy_during got low want high", name); end
        tests++; if (early_valid) begin fails++; $display("[TB] FAIL %s_early_valid got high want low", name); end
        tests++; if (rvalid !== 1'b1) begin fails++; $display("[TB] FAIL %s_valid got %b want 1", name, rvalid); end
        tests++; if (result !== exp_res) begin fails++; $display("[TB] FAIL %s_result got %0d want %0d", name, result, exp_res); end
        tests++; if (sat !== exp_sat) begin fails++; $display("[TB] FAIL %s_sat got %b want %b", name, sat, exp_sat); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("[TB] FAIL %s_busy_hold got %b want 0", name, busy); end
        do_handshake();
        tests++; if (rvalid !== 1'b0) begin fails++; $display("[TB] FAIL %s_valid_drop got %b want 0", name, rvalid); end
        tests++; if (result !== exp_res) begin fails++; $display("[TB] FAIL %s_result_kept got %0d want %0d", name, result, exp_res); end
    endtask

    task automatic test_reset_mid_window;
        do_start();
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        repeat (100) tick();
        bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (busy !== 1'b0 || rvalid !== 1'b0 || result !== 8'h00 || sat !== 1'b0) begin
            fails++; $display("[TB] FAIL midreset_outputs got busy=%b valid=%b result=%h sat=%b want all 0",
                              busy, rvalid, result, sat);
        end
        tests++; if (u_dut.u_counter.sample_cnt !== 8'd0) begin
            fails++; $display("[TB] FAIL midreset_sample_cnt got %0d want 0", u_dut.u_counter.sample_cnt);
        end
        tick();
        test_window("after_reset", 0, 1'b0, 8'hFF, 1'b1);
    endtask

    task automatic test_back_to_back;
        bit busy_ok, early_valid;
        logic [7:0] held;
        do_start();
        applyStimulus(1, 1'b0, busy_ok, early_valid);
        held = 8'd128;
        tests++; if (result !== held) begin fails++; $display("[TB] FAIL b2b_first got %0d want %0d", result, held); end
        for (int c = 0; c < 10; c++) begin
            start = (c == 5);
            tick();
            tests++; if (result !== held || rvalid !== 1'b1 || busy !== 1'b0) begin
                fails++; $display("[TB] FAIL b2b_hold_%0d got result=%0d valid=%b busy=%b want %0d/1/0",
                                  c, result, rvalid, busy, held);
            end
        end
        start = 1'b0;
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b0;
        tests++; if (busy !== 1'b1 || rvalid !== 1'b0) begin
            fails++; $display("[TB] FAIL b2b_restart got busy=%b valid=%b want 1/0", busy, rvalid);
        end
        tests++; if (u_dut.u_counter.sample_cnt !== 8'd0 || u_dut.u_counter.ones_cnt !== 9'd0) begin
            fails++; $display("[TB] FAIL b2b_counters got samples=%0d ones=%0d want 0/0",
                              u_dut.u_counter.sample_cnt, u_dut.u_counter.ones_cnt);
        end
        applyStimulus(2, 1'b0, busy_ok, early_valid);
        tests++; if (rvalid !== 1'b1 || result !== 8'd0 || sat !== 1'b0) begin
            fails++; $display("[TB] FAIL b2b_second got valid=%b result=%0d sat=%b want 1/0/0", rvalid, result, sat);
        end
        do_handshake();
    endtask

    task automatic test_long_window;
        bit early;
        early = 1'b0;
        start10 = 1'b1;
        tick();
        start10 = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            bit_valid10 = 1'b1;
            bit_in10    = (k % 4) != 3;
            tick();
            if (k < 1023 && rvalid10 !== 1'b0) early = 1'b1;
        end
        bit_valid10 = 1'b0;
        tests++; if (early) begin fails++; $display("[TB] FAIL long_early_valid got high want low"); end
        tests++; if (rvalid10 !== 1'b1 || result10 !== 8'd192 || sat10 !== 1'b0) begin
            fails++; $display("[TB] FAIL long_result got valid=%b result=%0d sat=%b want 1/192/0",
                              rvalid10, result10, sat10);
        end
        ready10 = 1'b1;
        tick();
        ready10 = 1'b0;
        tests++; if (rvalid10 !== 1'b0) begin fails++; $display("[TB] FAIL long_valid_drop got %b want 0", rvalid10); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; ready = 1'b0;
        start10 = 1'b0; bit_valid10 = 1'b0; bit_in10 = 1'b0; ready10 = 1'b0;
        test_reset();
        test_window("all_ones", 0, 1'b0, 8'hFF, 1'b1);
        test_window("alternating", 1, 1'b0, 8'h80, 1'b0);
        test_window("all_zeros", 2, 1'b0, 8'h00, 1'b0);
        test_window("gapped_1110", 3, 1'b1, 8'd192, 1'b0);
        test_reset_mid_window();
        test_back_to_back();
        test_long_window();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
